// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the handshaked memory stage.
package mem_pkg;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ACCESS   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

    // Access size comes from op[1:0]; the low address bits must be zero within that size.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] addr_lo);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

    function automatic logic is_illegal(input logic ld, input logic st,
                                        input logic [2:0] op, input int xlen);
        if (ld && st)
            return 1'b1;
        if (!ld && !st)
            return 1'b0;
        if (op == 3'b111)
            return 1'b1;
        if (xlen == 32 && (op == LSU_D || op == LSU_WU))
            return 1'b1;
        return 1'b0;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data, load extract + extend.
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 i_st_op,
    input  logic [$clog2(XLEN/8)-1:0]  i_st_off,
    input  logic [XLEN-1:0]            i_wdata,
    input  logic [2:0]                 i_ld_op,
    input  logic [$clog2(XLEN/8)-1:0]  i_ld_off,
    input  logic [XLEN-1:0]            i_rdata,
    output logic [XLEN/8-1:0]          o_be,
    output logic [XLEN-1:0]            o_wdata,
    output logic [XLEN-1:0]            o_rdata
);
    localparam int NB = XLEN/8;

    logic [3:0]      w_st_bytes, w_ld_bytes;
    logic [NB-1:0]   w_bm;
    logic [XLEN-1:0] w_shift, w_mask, w_top;
    logic            w_sign;

    always_comb begin
        w_st_bytes = 4'd1 << i_st_op[1:0];
        w_ld_bytes = 4'd1 << i_ld_op[1:0];
        w_bm       = '0;
        w_mask     = '0;
        o_wdata    = '0;
        for (int b = 0; b < NB; b++) begin
            w_bm[b]           = (b < int'(w_st_bytes));
            w_mask[8*b +: 8]  = (b < int'(w_ld_bytes)) ? 8'hFF : 8'h00;
            // Each byte lane repeats the low bytes of the store data at the access granularity.
            o_wdata[8*b +: 8] = i_wdata[8*(b & (int'(w_st_bytes) - 1)) +: 8];
        end
        o_be    = w_bm << i_st_off;
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        w_top   = w_mask & ~(w_mask >> 1);
        w_sign  = !i_ld_op[2] && |(w_shift & w_top);
        o_rdata = (w_shift & w_mask) | (w_sign ? ~w_mask : '0);
    end
endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage between execute and writeback: valid/ready in and out, req/gnt/rvalid data bus.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_load_i,
    input  logic              in_store_i,
    input  logic [2:0]        lsu_op_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic [4:0]        rd_idx_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN/8-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic              dmem_err_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_rd_data_o,
    output logic [4:0]        out_rd_idx_o,
    output logic              out_we_o,
    output logic              out_exc_o,
    output logic [1:0]        out_cause_o
);
    localparam int NB   = XLEN/8;
    localparam int OFFW = $clog2(NB);

    state_t            r_state;
    logic              r_req, r_dwe, r_is_load, r_full, r_we, r_exc;
    logic [NB-1:0]     r_be;
    logic [XLEN-1:0]   r_addr, r_wdata, r_rd_data;
    logic [2:0]        r_op;
    logic [OFFW-1:0]   r_off;
    logic [4:0]        r_rd, r_rd_idx;
    logic [1:0]        r_cause;
    logic [31:0]       r_cnt;

    logic              w_accept, w_illegal, w_misal, w_mem, w_tmo;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata, w_ld_data;

    assign in_ready_o = (r_state == ST_IDLE) && (!r_full || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_illegal  = is_illegal(in_load_i, in_store_i, lsu_op_i, XLEN);
    assign w_misal    = (in_load_i || in_store_i) && is_misaligned(lsu_op_i, addr_i[2:0]);
    assign w_mem      = (in_load_i ^ in_store_i) && !w_illegal && !w_misal;
    assign w_tmo      = (TIMEOUT != 0) && (r_cnt >= 32'(TIMEOUT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_st_op  (lsu_op_i),
        .i_st_off (addr_i[OFFW-1:0]),
        .i_wdata  (wr_data_i),
        .i_ld_op  (r_op),
        .i_ld_off (r_off),
        .i_rdata  (dmem_rdata_i),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_dwe     <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op      <= '0;
            r_off     <= '0;
            r_is_load <= 1'b0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_full    <= 1'b0;
            r_rd_data <= '0;
            r_rd_idx  <= '0;
            r_we      <= 1'b0;
            r_exc     <= 1'b0;
            r_cause   <= '0;
        end else begin
            if (r_full && out_ready_i)
                r_full <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_cnt <= '0;
                    if (w_mem) begin
                        r_state   <= ST_REQ;
                        r_req     <= 1'b1;
                        r_dwe     <= in_store_i;
                        r_be      <= w_be;
                        r_addr    <= {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
                        r_wdata   <= w_wdata;
                        r_op      <= lsu_op_i;
                        r_off     <= addr_i[OFFW-1:0];
                        r_is_load <= in_load_i;
                        r_rd      <= rd_idx_i;
                    end else begin
                        // Pass-through, or a fault detected at decode; the address doubles as fault info.
                        r_full    <= 1'b1;
                        r_rd_data <= addr_i;
                        r_rd_idx  <= rd_idx_i;
                        r_we      <= !(w_illegal || w_misal);
                        r_exc     <= w_illegal || w_misal;
                        r_cause   <= w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_tmo) begin
                        r_req     <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_full    <= 1'b1;
                        r_rd_data <= '0;
                        r_rd_idx  <= r_rd;
                        r_we      <= 1'b0;
                        r_exc     <= 1'b1;
                        r_cause   <= CAUSE_TIMEOUT;
                    end else if (dmem_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (dmem_rvalid_i) begin
                        r_state   <= ST_IDLE;
                        r_full    <= 1'b1;
                        r_rd_data <= (r_is_load && !dmem_err_i) ? w_ld_data : '0;
                        r_rd_idx  <= r_rd;
                        r_we      <= r_is_load && !dmem_err_i;
                        r_exc     <= dmem_err_i;
                        r_cause   <= CAUSE_ACCESS;
                    end else if (w_tmo) begin
                        r_state   <= ST_IDLE;
                        r_full    <= 1'b1;
                        r_rd_data <= '0;
                        r_rd_idx  <= r_rd;
                        r_we      <= 1'b0;
                        r_exc     <= 1'b1;
                        r_cause   <= CAUSE_TIMEOUT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_o    = r_req;
    assign dmem_we_o     = r_dwe;
    assign dmem_be_o     = r_be;
    assign dmem_addr_o   = r_addr;
    assign dmem_wdata_o  = r_wdata;
    assign out_valid_o   = r_full;
    assign out_rd_data_o = r_rd_data;
    assign out_rd_idx_o  = r_rd_idx;
    assign out_we_o      = r_we;
    assign out_exc_o     = r_exc;
    assign out_cause_o   = r_cause;
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Handshaked, parametrised memory stage for the RISC-V pipeline, sitting between execute and writeback. It accepts one load, store or pass-through op per transaction over valid/ready. It drives a request/grant/response data-memory bus with byte enables and lane-aligned write data, and returns an extracted, sign/zero-extended load result with exception information. It replaces the purely combinational stage so that memories with variable latency, including stalling and error-returning memories, can be attached.

## Interface
- XLEN, 32: data/address width; 32 or 64.
- TIMEOUT, 255: cycles allowed in REQ+RSP before a timeout fault; 0 disables the timeout.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active low; one clock domain.
- in_valid_i / in_ready_o  in/out  1  transaction handshake from execute.
- in_load_i, in_store_i  in  1  op class; both 0 = pass-through; both 1 is illegal.
- lsu_op_i  in  3  funct3 size/sign: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
- addr_i  in  XLEN  effective address, or the pass-through result.
- wr_data_i  in  XLEN  store data, right-aligned.
- rd_idx_i  in  5  destination register.
- dmem_req_o, dmem_we_o  out  1  bus request; write strobe.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_addr_o  out  XLEN  address, aligned down to XLEN/8.
- dmem_wdata_o  out  XLEN  lane-aligned store data.
- dmem_gnt_i, dmem_rvalid_i, dmem_err_i  in  1  grant; response valid; response error.
- dmem_rdata_i  in  XLEN  read data.
- out_valid_o / out_ready_i  out/in  1  result handshake to writeback.
- out_rd_data_o  out  XLEN  result.
- out_rd_idx_o  out  5  destination register.
- out_we_o  out  1  register write enable: load or pass-through, and no exception.
- out_exc_o  out  1  exception flag.
- out_cause_o  out  2  exception cause: 0 misaligned, 1 access fault, 2 timeout, 3 illegal op.

## Operation
- FSM states:
  - IDLE: accept transactions.
  - REQ: dmem_req_o held high until grant.
  - RSP: wait for the bus response.
- The output register is a single slot with a full flag. That flag drives out_valid_o.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
- Pass-through op: out_rd_data_o = addr_i, out_we_o = 1. The slot loads on acceptance; no bus activity.
- Illegal op (both class bits set, LD/LWU/011/110 when XLEN=32, or 111): no bus activity, slot loads with cause 3.
- Misaligned access (address not a multiple of the access size): no bus activity, slot loads with cause 0.
- Legal load or store:
  - Acceptance captures addr, op, data and rd and moves the FSM to REQ.
  - dmem_* signals are driven from registers and stay stable while dmem_req_o is high.
- REQ -> RSP on dmem_gnt_i. dmem_req_o drops in the cycle after the grant.
- RSP -> IDLE on dmem_rvalid_i. The slot loads at that point.
  - Load without error: extracted data, out_we_o = 1.
  - Store without error: out_we_o = 0.
  - dmem_err_i set: cause 1, out_we_o = 0.
- The timeout counter clears on acceptance and increments in REQ and RSP. On reaching TIMEOUT:
  - dmem_req_o drops.
  - The slot loads with cause 2 and the FSM returns to IDLE.
  - Any later response for that transaction is ignored, i.e. outside IDLE-tracked state.
- Store alignment: wdata = wr_data_i replicated into the lane at addr[log2(XLEN/8)-1:0]. be marks exactly the accessed bytes.
- Load extraction: dmem_rdata_i is shifted right by offset×8, then sign- or zero-extended to XLEN according to lsu_op.
- dmem_rvalid_i in IDLE or REQ is ignored.

## Timing
- Reset values:
  - state IDLE, slot empty, all dmem_* outputs 0, all out_* outputs 0.
  - in_ready_o = 1 after reset.
- Latency:
  - Pass-through, misaligned and illegal ops: out_valid_o in the cycle after acceptance.
  - Memory op accepted at cycle T: dmem_req_o high at T+1. With grant at T+1 and rvalid at T+2, out_valid_o is high at T+3.
- out_valid_o and the out_* signals hold stable until out_ready_i. A new transaction can be accepted in the same cycle the slot drains.
- Reset asserted mid-transaction: immediate return to IDLE, dmem_req_o low, the slot cleared.

## Structure
- Package mem_pkg holds:
  - lsu_op encodings.
  - cause codes.
  - state enum.
  - A misalignment function of (op, addr) for XLEN.
- Sub-module lsu_align is purely combinational: be/wdata generation and load extraction, parametrised by XLEN.
- The top level keeps the FSM, capture registers, timeout counter and output slot.

## Test plan
- XLEN=32, SB of wr_data 0x000000A5 to 0x1003 → be 1000, wdata 0xA5A5A5A5 (replicated), dmem_addr 0x1000; after rvalid: out_we_o 0, out_exc_o 0.
- LH at 0x2002; memory returns 0x80120000 after a 3-cycle grant stall → dmem_req_o held for 3 cycles, out_rd_data 0xFFFF8012, out_we_o 1.
- LW at 0x3001 → no dmem_req_o; next cycle out_exc_o 1, cause 0.
- XLEN=64, LWU at 0x4004 with rdata 0xDEADBEEF_00000000 → result 0x00000000DEADBEEF.
- Grant then dmem_err_i with rvalid → cause 1. Separately, TIMEOUT=8 with no grant → dmem_req_o drops after 8 cycles, cause 2.
- out_ready_i held low for 4 cycles with a result pending → out_* stable and in_ready_o low throughout. Back-to-back pass-through ops with out_ready_i=1 → one result per cycle.
